// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: opcodes, FSM states and entry field widths.
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int PC_W     = 32;
    localparam int TAKEN_W  = 1;
    localparam int UPD_PC_W = 8;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } brState_t;

    // True for every opcode that gets an entry in the prediction queue.
    function automatic logic isControlOp(input logic [6:0] opcode);
        return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// Circular FIFO of in-flight predictions; clear wins over push and pop in the same cycle.
module pred_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; the count alone decides which slots are live.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares each resolved control instruction with its queued gshare prediction,
// flushes and redirects on a mispredict, and feeds the outcome back to the predictor.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GHR_W     = 8,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enq_valid,
    output logic                o_enq_ready,
    input  logic [PC_W-1:0]     i_enq_pc,
    input  logic                i_enq_pred_taken,
    input  logic [PC_W-1:0]     i_enq_pred_target,
    input  logic [GHR_W-1:0]    i_enq_ghr,
    input  logic                i_res_valid,
    input  logic                i_res_taken,
    input  logic [PC_W-1:0]     i_res_target,
    output logic                o_flush,
    output logic [PC_W-1:0]     o_redirect_pc,
    output logic                o_upd_valid,
    output logic [UPD_PC_W-1:0] o_upd_pc,
    output logic                o_upd_taken,
    output logic [GHR_W-1:0]    o_upd_ghr,
    output logic [CNT_W-1:0]    o_resolved_cnt,
    output logic [CNT_W-1:0]    o_mispred_cnt,
    output logic                o_err_underflow
);

    localparam int ENTRY_W = PC_W + TAKEN_W + PC_W + GHR_W;
    localparam int QCNT_W  = $clog2(DEPTH) + 1;
    localparam int RCNT_W  = $clog2(FLUSH_CYC + 1);

    brState_t            r_state;
    brState_t            w_stateNext;
    logic [RCNT_W-1:0]   r_cnt;
    logic [RCNT_W-1:0]   w_cntNext;

    logic [ENTRY_W-1:0]  w_enqEntry;
    logic [ENTRY_W-1:0]  w_headEntry;
    logic [QCNT_W-1:0]   w_count;
    logic [PC_W-1:0]     w_headPc;
    logic                w_headTaken;
    logic [PC_W-1:0]     w_headTarget;
    logic [GHR_W-1:0]    w_headGhr;

    logic                w_isRun;
    logic                w_push;
    logic                w_resolve;
    logic                w_underflow;
    logic                w_mispredict;
    logic                w_squash;

    logic                r_flush;
    logic [PC_W-1:0]     r_redirectPc;
    logic                r_updValid;
    logic [UPD_PC_W-1:0] r_updPc;
    logic                r_updTaken;
    logic [GHR_W-1:0]    r_updGhr;
    logic [CNT_W-1:0]    r_resolvedCnt;
    logic [CNT_W-1:0]    r_mispredCnt;
    logic                r_errUnderflow;

    assign w_enqEntry   = {i_enq_pc, i_enq_pred_taken, i_enq_pred_target, i_enq_ghr};
    assign w_headPc     = w_headEntry[ENTRY_W-1 -: PC_W];
    assign w_headTaken  = w_headEntry[PC_W+GHR_W];
    assign w_headTarget = w_headEntry[PC_W+GHR_W-1 -: PC_W];
    assign w_headGhr    = w_headEntry[GHR_W-1:0];

    assign w_isRun      = (r_state == ST_RUN);
    assign o_enq_ready  = (w_count != QCNT_W'(DEPTH)) && w_isRun;
    assign w_push       = i_enq_valid && o_enq_ready;
    assign w_resolve    = w_isRun && i_res_valid && (w_count != '0);
    assign w_underflow  = w_isRun && i_res_valid && (w_count == '0);
    assign w_mispredict = (i_res_taken != w_headTaken) ||
                          (i_res_taken && w_headTaken && (i_res_target != w_headTarget));
    assign w_squash     = w_resolve && w_mispredict;

    pred_queue #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_predQueue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_resolve),
        .i_clear (w_squash),
        .i_data  (w_enqEntry),
        .o_head  (w_headEntry),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Leaving RECOVER on the decrement that reaches zero keeps enq_ready low for exactly FLUSH_CYC cycles.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_squash) begin
                    w_stateNext = ST_RECOVER;
                    w_cntNext   = RCNT_W'(FLUSH_CYC);
                end
            end
            ST_RECOVER: begin
                if (r_cnt <= RCNT_W'(1)) begin
                    w_stateNext = ST_RUN;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext   = r_cnt - RCNT_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_RUN;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flush        <= 1'b0;
            r_redirectPc   <= '0;
            r_updValid     <= 1'b0;
            r_updPc        <= '0;
            r_updTaken     <= 1'b0;
            r_updGhr       <= '0;
            r_resolvedCnt  <= '0;
            r_mispredCnt   <= '0;
            r_errUnderflow <= 1'b0;
        end else begin
            r_flush    <= w_squash;
            r_updValid <= w_resolve;
            if (w_resolve) begin
                r_updPc    <= w_headPc[UPD_PC_W-1:0];
                r_updTaken <= i_res_taken;
                r_updGhr   <= w_headGhr;
                if (r_resolvedCnt != '1) begin
                    r_resolvedCnt <= r_resolvedCnt + CNT_W'(1);
                end
            end
            if (w_squash) begin
                r_redirectPc <= i_res_taken ? i_res_target : (w_headPc + PC_W'(4));
                if (r_mispredCnt != '1) begin
                    r_mispredCnt <= r_mispredCnt + CNT_W'(1);
                end
            end
            if (w_underflow) begin
                r_errUnderflow <= 1'b1;
            end
        end
    end

    assign o_flush         = r_flush;
    assign o_redirect_pc   = r_redirectPc;
    assign o_upd_valid     = r_updValid;
    assign o_upd_pc        = r_updPc;
    assign o_upd_taken     = r_updTaken;
    assign o_upd_ghr       = r_updGhr;
    assign o_resolved_cnt  = r_resolvedCnt;
    assign o_mispred_cnt   = r_mispredCnt;
    assign o_err_underflow = r_errUnderflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int DEPTH     = 4;
    localparam int GHR_W     = 8;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [31:0]       enq_pc = '0;
    logic              enq_pred_taken = 1'b0;
    logic [31:0]       enq_pred_target = '0;
    logic [GHR_W-1:0]  enq_ghr = '0;
    logic              res_valid = 1'b0;
    logic              res_taken = 1'b0;
    logic [31:0]       res_target = '0;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic              upd_valid;
    logic [7:0]        upd_pc;
    logic              upd_taken;
    logic [GHR_W-1:0]  upd_ghr;
    logic [CNT_W-1:0]  resolved_cnt;
    logic [CNT_W-1:0]  mispred_cnt;
    logic              err_underflow;

    typedef struct {
        logic [31:0]      pc;
        logic             taken;
        logic [31:0]      target;
        logic [GHR_W-1:0] ghr;
    } entry_t;

    entry_t           mq[$];
    int               recoverLeft;
    logic [31:0]      mResolved, mMispred, mRedirect;
    logic             mErr, mFlush, mUpdValid, mUpdTaken;
    logic [7:0]       mUpdPc;
    logic [GHR_W-1:0] mUpdGhr;
    int               checkCount = 0;
    int               errorCount = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DEPTH     (DEPTH),
        .GHR_W     (GHR_W),
        .FLUSH_CYC (FLUSH_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_enq_valid       (enq_valid),
        .o_enq_ready       (enq_ready),
        .i_enq_pc          (enq_pc),
        .i_enq_pred_taken  (enq_pred_taken),
        .i_enq_pred_target (enq_pred_target),
        .i_enq_ghr         (enq_ghr),
        .i_res_valid       (res_valid),
        .i_res_taken       (res_taken),
        .i_res_target      (res_target),
        .o_flush           (flush),
        .o_redirect_pc     (redirect_pc),
        .o_upd_valid       (upd_valid),
        .o_upd_pc          (upd_pc),
        .o_upd_taken       (upd_taken),
        .o_upd_ghr         (upd_ghr),
        .o_resolved_cnt    (resolved_cnt),
        .o_mispred_cnt     (mispred_cnt),
        .o_err_underflow   (err_underflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic modelReady();
        return (mq.size() != DEPTH) && (recoverLeft == 0);
    endfunction

    task automatic modelReset();
        mq.delete();
        recoverLeft = 0;
        mResolved = 0; mMispred = 0; mRedirect = 0;
        mErr = 0; mFlush = 0; mUpdValid = 0; mUpdTaken = 0; mUpdPc = 0; mUpdGhr = 0;
    endtask

    // One clock of the reference: a FIFO of predictions plus a recovery countdown.
    task automatic modelStep(input logic enqV, input entry_t e, input logic resV,
                             input logic rt, input logic [31:0] rtgt);
        logic   ready;
        logic   mis;
        entry_t h;
        ready     = modelReady();
        mFlush    = 0;
        mUpdValid = 0;
        if (recoverLeft > 0) begin
            recoverLeft--;
        end else if (resV && mq.size() > 0) begin
            h = mq.pop_front();
            mis = (rt != h.taken) || (rt && h.taken && rtgt != h.target);
            mUpdValid = 1;
            mUpdPc    = h.pc[7:0];
            mUpdTaken = rt;
            mUpdGhr   = h.ghr;
            if (mResolved != 32'hFFFF_FFFF) mResolved++;
            if (mis) begin
                mFlush    = 1;
                mRedirect = rt ? rtgt : h.pc + 32'd4;
                mq.delete();
                if (mMispred != 32'hFFFF_FFFF) mMispred++;
                recoverLeft = FLUSH_CYC;
            end else if (enqV && ready) begin
                mq.push_back(e);
            end
        end else begin
            if (resV) mErr = 1;
            if (enqV && ready) mq.push_back(e);
        end
    endtask

    task automatic compareAll();
        checkOutput("enq_ready", enq_ready, modelReady());
        checkOutput("flush", flush, mFlush);
        checkOutput("upd_valid", upd_valid, mUpdValid);
        if (mFlush) checkOutput("redirect_pc", redirect_pc, mRedirect);
        if (mUpdValid) begin
            checkOutput("upd_pc", upd_pc, mUpdPc);
            checkOutput("upd_taken", upd_taken, mUpdTaken);
            checkOutput("upd_ghr", upd_ghr, mUpdGhr);
        end
        checkOutput("resolved_cnt", resolved_cnt, mResolved);
        checkOutput("mispred_cnt", mispred_cnt, mMispred);
        checkOutput("err_underflow", err_underflow, mErr);
    endtask

    // Drives one cycle of inputs from a negedge, steps the model at the edge, checks at the next negedge.
    task automatic applyStimulus(input logic enqV, input logic [31:0] pc, input logic pt,
                                 input logic [31:0] ptgt, input logic [GHR_W-1:0] ghr,
                                 input logic resV, input logic rt, input logic [31:0] rtgt);
        entry_t e;
        e.pc = pc; e.taken = pt; e.target = ptgt; e.ghr = ghr;
        enq_valid = enqV; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = ptgt; enq_ghr = ghr;
        res_valid = resV; res_taken = rt; res_target = rtgt;
        @(posedge clk);
        modelStep(enqV, e, resV, rt, rtgt);
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        enq_valid = 1'b0;
        res_valid = 1'b0;
        @(posedge clk);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_enq_ready", enq_ready, 32'd1);
        checkOutput("rst_flush", flush, 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst_upd_valid", upd_valid, 32'd0);
        checkOutput("rst_upd_pc", upd_pc, 32'd0);
        checkOutput("rst_upd_ghr", upd_ghr, 32'd0);
        checkOutput("rst_resolved_cnt", resolved_cnt, 32'd0);
        checkOutput("rst_mispred_cnt", mispred_cnt, 32'd0);
        checkOutput("rst_err_underflow", err_underflow, 32'd0);
    endtask

    initial begin
        logic              rEnq, rPt, rRes, rRt;
        logic [31:0]       rPc, rTgt, rResTgt;
        logic [GHR_W-1:0]  rGhr;

        $display("[TB] starting branch_resolve_unit bench");
        modelReset();
        doReset();

        // Correct taken prediction.
        applyStimulus(1, 32'h100, 1, 32'h140, 8'h11, 0, 0, 32'h0);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 1, 32'h140);
        checkOutput("t1_upd_pc", upd_pc, 32'h00);
        checkOutput("t1_resolved", resolved_cnt, 32'd1);

        // Direction mispredict, then the recovery window.
        applyStimulus(1, 32'h200, 1, 32'h240, 8'h22, 0, 0, 32'h0);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 0, 32'h0);
        checkOutput("t2_redirect", redirect_pc, 32'h204);
        checkOutput("t2_ready_c1", enq_ready, 32'd0);
        idleCycle();
        checkOutput("t2_ready_c2", enq_ready, 32'd0);
        idleCycle();
        checkOutput("t2_ready_c3", enq_ready, 32'd1);

        // Target mispredict on a jalr.
        applyStimulus(1, 32'h2F0, 1, 32'h300, 8'h33, 0, 0, 32'h0);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 1, 32'h380);
        checkOutput("t3_redirect", redirect_pc, 32'h380);
        idleCycle();
        idleCycle();

        // Fill the queue, then exercise same-cycle push and pop.
        applyStimulus(1, 32'h10, 0, 32'h0, 8'h01, 0, 0, 32'h0);
        applyStimulus(1, 32'h20, 1, 32'h80, 8'h02, 0, 0, 32'h0);
        applyStimulus(1, 32'h30, 0, 32'h0, 8'h03, 0, 0, 32'h0);
        applyStimulus(1, 32'h40, 1, 32'hC0, 8'h04, 0, 0, 32'h0);
        checkOutput("t4_full_ready", enq_ready, 32'd0);
        applyStimulus(1, 32'h50, 0, 32'h0, 8'h05, 1, 0, 32'h0);
        checkOutput("t4_pop0", upd_pc, 32'h10);
        applyStimulus(1, 32'h60, 0, 32'h0, 8'h06, 1, 1, 32'h80);
        checkOutput("t4_pop1", upd_pc, 32'h20);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 0, 32'h0);
        checkOutput("t4_pop2", upd_pc, 32'h30);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 1, 32'hC0);
        checkOutput("t4_pop3", upd_pc, 32'h40);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 0, 32'h0);
        checkOutput("t4_pop4", upd_pc, 32'h60);

        // Mispredict squashes a same-cycle enqueue; a later resolve finds the queue empty.
        applyStimulus(1, 32'h70, 0, 32'h0, 8'h07, 0, 0, 32'h0);
        applyStimulus(1, 32'h80, 0, 32'h0, 8'h08, 1, 1, 32'h90);
        checkOutput("t5_redirect", redirect_pc, 32'h90);
        idleCycle();
        idleCycle();
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 0, 32'h0);
        checkOutput("t6_underflow", err_underflow, 32'd1);
        checkOutput("t6_no_upd", upd_valid, 32'd0);

        // Reset while in RECOVER.
        applyStimulus(1, 32'hA0, 0, 32'h0, 8'h0A, 0, 0, 32'h0);
        applyStimulus(0, 32'h0, 0, 32'h0, '0, 1, 1, 32'hB0);
        idleCycle();
        doReset();

        // Randomized traffic, biased so many resolves match the head prediction.
        for (int i = 0; i < 400; i++) begin
            rEnq    = ($urandom_range(0, 99) < 60);
            rPc     = $urandom & 32'hFFFF_FFFC;
            rPt     = 1'($urandom_range(0, 1));
            rTgt    = $urandom & 32'hFFFF_FFFC;
            rGhr    = GHR_W'($urandom);
            rRes    = ($urandom_range(0, 99) < 45);
            rRt     = 1'($urandom_range(0, 1));
            rResTgt = $urandom & 32'hFFFF_FFFC;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rRt     = mq[0].taken;
                rResTgt = mq[0].target;
            end else if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
                rResTgt = mq[0].target;
            end
            applyStimulus(rEnq, rPc, rPt, rTgt, rGhr, rRes, rRt, rResTgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
